// File: rtl/led_pwm_pkg.sv
// Shared constants and sizing helpers for the LED brightness/PWM path.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package led_pwm_pkg;

  localparam int PWM_W_DEF      = 4;
  localparam int DEB_CYCLES_DEF = 4;
  localparam int N_LED_DEF      = 3;
  localparam int INIT_LEVEL_DEF = 8;
  localparam int LVL_MAX        = 1 << PWM_W_DEF;

  // Full-brightness level for a given PWM counter width (one past the top count).
  function automatic int lvl_max(input int pwm_w);
    return 1 << pwm_w;
  endfunction

  // Debounce counter width; one spare bit so DEB_CYCLES-1 always fits.
  function automatic int deb_cnt_w(input int deb_cycles);
    return $clog2(deb_cycles) + 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, registered press pulse.
// Latency: press pulse 2 sync + DEB_CYCLES + 1 edges after the first edge sampling a steady press.
// Backpressure: none; one single-cycle pulse per press, nothing on release or while held.
module btn_debounce
  import led_pwm_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int              CW       = deb_cnt_w(DEB_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic          prev_q, prev_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Synchronize, count consecutive disagreeing cycles, flip stable after DEB_CYCLES of them.
  always_comb begin
    sync1_d  = btn;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    prev_d  = stable_q;
    press_d = stable_q & ~prev_q;
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/led_pwm_ctrl.sv
// Brightness level from debounced up/down buttons, driving N_LED glitch-free PWM outputs.
// Latency: level moves DEB_CYCLES+4 edges after a press is first sampled; duty follows at next period.
// Backpressure: none; level saturates at 0 and 2^PWM_W, PWM runs continuously.
module led_pwm_ctrl
  import led_pwm_pkg::*;
#(
  parameter int PWM_W      = PWM_W_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int N_LED      = N_LED_DEF,
  parameter int INIT_LEVEL = INIT_LEVEL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_dn,
  output logic [PWM_W:0]   level,
  output logic [N_LED-1:0] led
);

  localparam logic [PWM_W:0] LVL_TOP  = (PWM_W + 1)'(lvl_max(PWM_W));
  localparam logic [PWM_W:0] LVL_INIT = (PWM_W + 1)'(INIT_LEVEL);

  logic             up_pulse, dn_pulse;
  logic [PWM_W:0]   level_q, level_d;
  logic [PWM_W:0]   active_q, active_d;
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [N_LED-1:0] led_q, led_d;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_up),
    .press (up_pulse)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_dn),
    .press (dn_pulse)
  );

  // Saturating level step; simultaneous up and down presses cancel.
  always_comb begin
    level_d = level_q;
    if (up_pulse && !dn_pulse && (level_q != LVL_TOP)) begin
      level_d = level_q + (PWM_W + 1)'(1);
    end else if (dn_pulse && !up_pulse && (level_q != '0)) begin
      level_d = level_q - (PWM_W + 1)'(1);
    end
  end

  // PWM: shadow level only at the period wrap so a running period is never disturbed.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    active_d  = (&pwm_cnt_q) ? level_q : active_q;
    led_d     = '0;
    for (int i = 0; i < N_LED; i++) begin
      led_d[i] = ({1'b0, pwm_cnt_q} < (active_q >> i));
    end
  end

  // Level, PWM counter, shadow level and registered LED outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q   <= LVL_INIT;
      active_q  <= LVL_INIT;
      pwm_cnt_q <= '0;
      led_q     <= '0;
    end else begin
      level_q   <= level_d;
      active_q  <= active_d;
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
    end
  end

  assign level = level_q;
  assign led   = led_q;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Self-checking bench for led_pwm_ctrl against a behavioural history-based model.
// Latency: n/a.
// Backpressure: n/a.
module tb_led_pwm_ctrl;

  localparam int DEB  = 4;
  localparam int PER  = 16;
  localparam int LMAX = 16;
  localparam int INIT = 8;
  localparam int NL   = 3;
  localparam int HMAX = 4096;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up, btn_dn;
  logic [4:0] level;
  logic [2:0] led;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  led_pwm_ctrl #(.PWM_W(4), .DEB_CYCLES(DEB), .N_LED(NL), .INIT_LEVEL(INIT)) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_up (btn_up),
    .btn_dn (btn_dn),
    .level  (level),
    .led    (led)
  );

  // Model: raw samples per edge since reset; sample taken at edge m is seen by the
  // debouncer at edge m+2. A button's debounced state flips when the last DEB seen
  // samples all disagree with it. A press counted at edge n moves the level at n+2.
  bit   up_h [HMAX];
  bit   dn_h [HMAX];
  bit   rise_u [HMAX];
  bit   rise_d [HMAX];
  int   lvl_h [HMAX];
  int   act_h [HMAX];
  bit   st_u, st_d;
  int   m_n;
  int   exp_level;
  logic [2:0] exp_led;

  task automatic model_reset();
    m_n       = 0;
    st_u      = 0;
    st_d      = 0;
    lvl_h[0]  = INIT;
    act_h[0]  = INIT;
    rise_u[0] = 0;
    rise_d[0] = 0;
    exp_level = INIT;
    exp_led   = '0;
  endtask

  task automatic model_edge();
    bit fu, fd, pu, pd;
    int lv;
    m_n++;
    up_h[m_n] = btn_up;
    dn_h[m_n] = btn_dn;
    fu = 1;
    fd = 1;
    for (int k = 0; k < DEB; k++) begin
      int m;
      bit su, sd;
      m  = m_n - k;
      su = (m >= 3) ? up_h[m-2] : 1'b0;
      sd = (m >= 3) ? dn_h[m-2] : 1'b0;
      if (su == st_u) fu = 0;
      if (sd == st_d) fd = 0;
    end
    rise_u[m_n] = fu && !st_u;
    rise_d[m_n] = fd && !st_d;
    if (fu) st_u = !st_u;
    if (fd) st_d = !st_d;
    pu = (m_n >= 3) ? rise_u[m_n-2] : 1'b0;
    pd = (m_n >= 3) ? rise_d[m_n-2] : 1'b0;
    lv = lvl_h[m_n-1];
    if (pu && !pd && lv < LMAX) lv = lv + 1;
    if (pd && !pu && lv > 0)    lv = lv - 1;
    lvl_h[m_n] = lv;
    act_h[m_n] = (m_n % PER == 0) ? lvl_h[m_n-1] : act_h[m_n-1];
    for (int i = 0; i < NL; i++)
      exp_led[i] = (((m_n - 1) % PER) < (act_h[m_n-1] >> i));
    exp_level = lv;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_edge();
    #1;
  endtask

  task automatic apply_reset();
    btn_up = 0;
    btn_dn = 0;
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    model_reset();
    rst = 1;
  endtask

  // Stimulus only: hold the given buttons for hi cycles, then release for lo cycles.
  task automatic press(input bit u, input bit d, input int hi, input int lo);
    btn_up = u;
    btn_dn = d;
    repeat (hi) step();
    btn_up = 0;
    btn_dn = 0;
    repeat (lo) step();
  endtask

  task automatic test_reset();
    int c0, c1, c2;
    btn_up = 0;
    btn_dn = 0;
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (level !== 5'd8 || led !== 3'b000) begin
        fails++;
        $display("FAIL reset_hold: level=%0d led=%b, want level=8 led=000", level, led);
      end
    end
    model_reset();
    rst = 1;
    c0 = 0; c1 = 0; c2 = 0;
    for (int k = 0; k < PER; k++) begin
      step();
      c0 += led[0];
      c1 += led[1];
      c2 += led[2];
      tests++;
      if (led !== exp_led || level !== 5'(exp_level)) begin
        fails++;
        $display("FAIL reset_first_period: cyc=%0d led=%b level=%0d, want led=%b level=%0d",
                 k, led, level, exp_led, exp_level);
      end
    end
    tests++;
    if (c0 != 8 || c1 != 4 || c2 != 2) begin
      fails++;
      $display("FAIL reset_duty_counts: got %0d/%0d/%0d, want 8/4/2", c0, c1, c2);
    end
  endtask

  task automatic test_clean_press();
    apply_reset();
    repeat ($urandom_range(0, 20)) step();
    btn_up = 1;
    for (int k = 1; k <= 20; k++) begin
      step();
      tests++;
      if (level !== 5'(exp_level) || led !== exp_led) begin
        fails++;
        $display("FAIL clean_press_model: k=%0d level=%0d led=%b, want %0d %b",
                 k, level, led, exp_level, exp_led);
      end
      if (k == 7 || k == 8) begin
        tests++;
        if (level !== ((k == 7) ? 5'd8 : 5'd9)) begin
          fails++;
          $display("FAIL clean_press_latency: edge %0d level=%0d, want %0d", k, level, (k == 7) ? 8 : 9);
        end
      end
    end
    btn_up = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      tests++;
      if (level !== 5'(exp_level) || led !== exp_led) begin
        fails++;
        $display("FAIL clean_press_duty: k=%0d level=%0d led=%b, want %0d %b",
                 k, level, led, exp_level, exp_led);
      end
    end
    tests++;
    if (level !== 5'd9) begin
      fails++;
      $display("FAIL clean_press_single: level=%0d, want 9", level);
    end
  endtask

  task automatic test_bounce();
    apply_reset();
    for (int r = 0; r < 6; r++) begin
      btn_dn = 1;
      repeat (2) step();
      btn_dn = 0;
      step();
      tests++;
      if (level !== 5'd8) begin
        fails++;
        $display("FAIL bounce_reject: round %0d level=%0d, want 8", r, level);
      end
    end
    repeat (10) step();
    tests++;
    if (level !== 5'd8 || exp_level != 8) begin
      fails++;
      $display("FAIL bounce_settled: level=%0d model=%0d, want 8", level, exp_level);
    end
    press(0, 1, 10, 10);
    tests++;
    if (level !== 5'd7) begin
      fails++;
      $display("FAIL bounce_then_hold: level=%0d, want 7", level);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int p = 1; p <= 10; p++) begin
      press(1, 0, 8, 8);
      if (p >= 9) begin
        tests++;
        if (level !== 5'd16) begin
          fails++;
          $display("FAIL sat_up: after %0d presses level=%0d, want 16", p, level);
        end
      end
    end
    repeat (2 * PER) step();
    for (int k = 0; k < PER; k++) begin
      step();
      tests++;
      if (led[0] !== 1'b1 || led !== exp_led) begin
        fails++;
        $display("FAIL sat_up_led: k=%0d led=%b, want led[0]=1 (model %b)", k, led, exp_led);
      end
    end
    apply_reset();
    for (int p = 1; p <= 17; p++) begin
      press(0, 1, 8, 8);
      if (p >= 16) begin
        tests++;
        if (level !== 5'd0) begin
          fails++;
          $display("FAIL sat_dn: after %0d presses level=%0d, want 0", p, level);
        end
      end
    end
    repeat (2 * PER) step();
    for (int k = 0; k < PER; k++) begin
      step();
      tests++;
      if (led !== 3'b000) begin
        fails++;
        $display("FAIL sat_dn_led: k=%0d led=%b, want 000", k, led);
      end
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    repeat ($urandom_range(1, 7)) step();
    btn_up = 1;
    btn_dn = 1;
    for (int k = 0; k < 20; k++) begin
      step();
      tests++;
      if (level !== 5'd8 || level !== 5'(exp_level)) begin
        fails++;
        $display("FAIL simultaneous: k=%0d level=%0d, want 8", k, level);
      end
    end
    press(0, 0, 0, 10);
    tests++;
    if (level !== 5'd8) begin
      fails++;
      $display("FAIL simultaneous_release: level=%0d, want 8", level);
    end
  endtask

  task automatic test_random();
    int cyc;
    apply_reset();
    cyc = 0;
    while (cyc < 1500) begin
      int len;
      len    = $urandom_range(1, 12);
      btn_up = 1'($urandom_range(0, 1));
      btn_dn = 1'($urandom_range(0, 1));
      for (int k = 0; k < len; k++) begin
        step();
        cyc++;
        tests++;
        if (level !== 5'(exp_level) || led !== exp_led) begin
          fails++;
          $display("FAIL random: cyc=%0d level=%0d led=%b, want %0d %b",
                   cyc, level, led, exp_level, exp_led);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    apply_reset();
    repeat (4) press(1, 0, 8, 8);
    tests++;
    if (level !== 5'd12) begin
      fails++;
      $display("FAIL reset_mid_setup: level=%0d, want 12", level);
    end
    guard = 0;
    while ((m_n % PER) != 5 && guard < PER) begin
      step();
      guard++;
    end
    tests++;
    if ((m_n % PER) != 5) begin
      fails++;
      $display("FAIL reset_mid_align: pwm phase=%0d, want 5", m_n % PER);
    end
    #2;
    rst = 0;
    #1;
    tests++;
    if (level !== 5'd8 || led !== 3'b000) begin
      fails++;
      $display("FAIL reset_mid_async: level=%0d led=%b, want 8 000", level, led);
    end
    @(negedge clk);
    model_reset();
    rst = 1;
    for (int k = 0; k < PER + 4; k++) begin
      step();
      if (k == 0) begin
        tests++;
        if (led !== 3'b111) begin
          fails++;
          $display("FAIL reset_mid_restart: first led=%b, want 111", led);
        end
      end
      tests++;
      if (level !== 5'(exp_level) || led !== exp_led) begin
        fails++;
        $display("FAIL reset_mid_period: k=%0d level=%0d led=%b, want %0d %b",
                 k, level, led, exp_level, exp_led);
      end
    end
  endtask

  initial begin
    rst    = 1;
    btn_up = 0;
    btn_dn = 0;
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_saturation();
    test_simultaneous();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete, tests=%0d fails=%0d", tests, fails);
    $fatal(1);
  end

endmodule

// File: doc/led_pwm_ctrl.md
Name: led_pwm_ctrl

Overview:
- Upstream brightness/PWM stage for the board LED dimming path.
- Debounces two push-buttons (up/down) and keeps a saturating brightness level.
- Produces glitch-free PWM waveforms on N_LED outputs; LED i runs at the level divided by 2^i.
- Its outputs drive board LEDs directly or feed the downstream dimming logic.

Parameters:
- PWM_W, 4, PWM counter width; period = 2^PWM_W cycles; level range 0..2^PWM_W.
- DEB_CYCLES, 4, consecutive stable cycles required before a debounced button changes state (small for simulation, raised for board).
- N_LED, 3, number of PWM outputs.
- INIT_LEVEL, 8, brightness level after reset; must satisfy 0..2^PWM_W.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- btn_up  in  1  raw asynchronous button; high = pressed.
- btn_dn  in  1  raw asynchronous button; high = pressed.
- level  out  PWM_W+1  current requested brightness level.
- led  out  N_LED  PWM outputs; led[i] has duty (active_level>>i)/2^PWM_W.

Behaviour:
- Reset (rst low, asynchronous):
  - Synchronizers, debounce counters, stable states and edge registers all clear to 0.
  - level = INIT_LEVEL, active_level = INIT_LEVEL, pwm_cnt = 0, led = 0.
- Synchronizer: 2-flop chain per button; only synchronized values are used downstream.
- Debounce, per button:
  - Counter deb_cnt (width clog2(DEB_CYCLES)+1).
  - If sync != stable, deb_cnt increments. When it reaches DEB_CYCLES-1 while still differing, stable flips and deb_cnt clears.
  - If sync == stable, deb_cnt clears.
  - A glitch shorter than DEB_CYCLES cycles never changes stable.
- Press pulse: registered rising-edge detect on stable gives a 1-cycle pulse per press. Releases produce no pulse, and holding a button does not auto-repeat.
- Level update (registered):
  - up pulse only: level+1, saturating at 2^PWM_W.
  - dn pulse only: level-1, saturating at 0.
  - Both in the same cycle: no change.
  - Saturated increment or decrement: no change, no wrap.
- Latency: with the button held steady, level changes on the (DEB_CYCLES+4)th rising edge after the first edge that samples btn high (2 sync + DEB_CYCLES debounce + 1 edge + 1 update).
- PWM:
  - pwm_cnt is free-running 0..2^PWM_W-1 and wraps to 0.
  - active_level loads from level only on the edge where pwm_cnt wraps from 2^PWM_W-1 to 0. A level change never alters the current period.
  - led[i] is registered: led[i] <= (pwm_cnt < (active_level >> i)), giving 1-cycle latency from pwm_cnt.
  - Level 0: constant low. Level 2^PWM_W: led[0] constant high.
  - Shifts are logical; widths are PWM_W+1 unsigned, compared against pwm_cnt zero-extended.
- Reset mid-period or mid-debounce: all state returns to reset values immediately. After release, the first PWM period starts at pwm_cnt = 0 with active_level = INIT_LEVEL.

Decomposition:
- Package led_pwm_pkg: LVL_MAX = 2^PWM_W, and a helper function for the debounce counter width.
- Sub-module btn_debounce (2-flop sync + stable counter + rising-edge pulse), instantiated twice, once per button.
- Top contains the level register, PWM counter, shadow active_level and led compare registers.

Test Plan:
- Reset value check: hold rst low 3 cycles, then release → level = 8, led = 000. In the first period, led[0] is high for 8 cycles, led[1] for 4, led[2] for 2, starting 1 cycle after pwm_cnt = 0.
- Clean press: btn_up held high for 20 cycles → level 8→9 exactly 8 edges after first sample (DEB_CYCLES = 4). Only one increment. The new duty appears only from the next pwm_cnt wrap.
- Bounce rejection: btn_dn toggles high 2 cycles / low 1 cycle repeatedly, then stays low → level stays 8. Then hold 10 cycles high → level = 7.
- Saturation: 9 up presses from reset → level = 16 and led[0] constantly high. A 10th press leaves level at 16. 16 down presses from reset → level = 0 and all led constant low; one more press leaves 0.
- Simultaneous presses: btn_up and btn_dn rise on the same cycle and are held → both pulses coincide, level unchanged at 8.
- Reset mid-operation: assert rst while pwm_cnt = 5 and level = 12 → led = 000 and level = 8 immediately, with no clock needed. After release, PWM restarts from pwm_cnt = 0.
